// File: rtl/jesd204_up_ilas_cfg_bank_pkg.sv
// Shared constants for the ILAS configuration bank: word layout, writable
// fields, checksum octet range and checksum FSM encoding.
package jesd204_up_pkg;

    localparam int WORD_CNT         = 4;
    localparam int OCTET_CNT        = 16;
    localparam int LANE_ID_W        = 5;
    localparam int W1_WR_LSB        = 5;
    localparam int W3_WR_MSB        = 23;
    localparam int FCHK_FIRST_OCTET = 0;
    localparam int FCHK_LAST_OCTET  = 13;

    localparam logic [31:0] WR_MASK_W0 = 32'hFFFF_FFFF;
    localparam logic [31:0] WR_MASK_W1 = 32'hFFFF_FFE0;
    localparam logic [31:0] WR_MASK_W2 = 32'hFFFF_FFFF;
    localparam logic [31:0] WR_MASK_W3 = 32'h00FF_FFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SUM   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    typedef logic [31:0] cfg_word_t;

    function automatic cfg_word_t wr_mask(input logic [1:0] word);
        case (word)
            2'd0:    return WR_MASK_W0;
            2'd1:    return WR_MASK_W1;
            2'd2:    return WR_MASK_W2;
            default: return WR_MASK_W3;
        endcase
    endfunction

endpackage

// File: rtl/jesd204_up_ilas_cfg_bank_if.sv
// Processor-side register bus of the ILAS configuration bank.
interface jesd204_up_ilas_cfg_bank_if #(
    parameter int ADDR_W = 2
) ();

    logic              up_wreq;
    logic [ADDR_W-1:0] up_waddr;
    logic [31:0]       up_wdata;
    logic              up_wbcast;
    logic              up_wack;
    logic              up_rreq;
    logic [ADDR_W-1:0] up_raddr;
    logic [31:0]       up_rdata;
    logic              up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_wbcast, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_wbcast, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );

endinterface

// File: rtl/jesd204_up_ilas_cfg_bank_fchk.sv
// Sequential octet summer: after start, adds one octet per cycle over the
// checksum octet range and pulses done with the mod-256 total.
module jesd204_up_ilas_fchk
    import jesd204_up_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] octet,
    output logic [3:0] octet_idx,
    output logic [7:0] sum,
    output logic       done
);

    logic run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            done      <= 1'b0;
            octet_idx <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run       <= 1'b1;
                octet_idx <= 4'(FCHK_FIRST_OCTET);
            end else if (run) begin
                if (octet_idx == 4'(FCHK_LAST_OCTET)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    octet_idx <= octet_idx + 4'd1;
                end
            end
        end
    end

    // The accumulator is only consumed on done, so it needs no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            sum <= '0;
        end else if (run) begin
            sum <= sum + octet;
        end
    end

endmodule

// File: rtl/jesd204_up_ilas_cfg_bank.sv
// Per-lane ILAS configuration storage with processor read/write access,
// background FCHK recomputation and a registered core-side read port.
module jesd204_up_ilas_cfg_bank
    import jesd204_up_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int DATA_PATH_WIDTH = 4,
    localparam int CORE_AW = $clog2(16 / DATA_PATH_WIDTH)
) (
    input  logic                                  up_clk,
    input  logic                                  up_reset,
    jesd204_up_ilas_cfg_bank_if.slave             up,
    input  logic                                  up_cfg_is_writeable,
    input  logic                                  core_ilas_config_rd,
    input  logic [CORE_AW-1:0]                    core_ilas_config_addr,
    output logic [NUM_LANES*8*DATA_PATH_WIDTH-1:0] core_ilas_config_data,
    output logic                                  up_fchk_busy
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int BEAT_W = 8 * DATA_PATH_WIDTH;
    localparam int WPB    = DATA_PATH_WIDTH / 4;

    logic [31:0]          word0    [NUM_LANES];
    logic [31:W1_WR_LSB]  word1_hi [NUM_LANES];
    logic [31:0]          word2    [NUM_LANES];
    logic [W3_WR_MSB:0]   word3_lo [NUM_LANES];
    logic [7:0]           fchk     [NUM_LANES];

    logic [NUM_LANES-1:0][WORD_CNT-1:0][3:0][7:0] view;
    logic [NUM_LANES-1:0]        dirty;
    logic [NUM_LANES-1:0]        dirty_set;
    logic [NUM_LANES-1:0]        dirty_clr;
    logic [1:0]                  state;
    logic [LANE_W-1:0]           cur_lane;
    logic [LANE_W-1:0]           first_dirty;
    logic [31:0]                 rd_word;
    logic [NUM_LANES*BEAT_W-1:0] core_beat;
    logic                        start;
    logic                        done;
    logic [3:0]                  octet_idx;
    logic [7:0]                  octet;
    logic [7:0]                  sum;
    int                          wlane;
    int                          rlane;

    assign wlane = int'(up.up_waddr >> 2);
    assign rlane = int'(up.up_raddr >> 2);

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            view[l] = {fchk[l], word3_lo[l], word2[l], word1_hi[l],
                       LANE_ID_W'(l), word0[l]};
        end
    end

    always_comb begin
        dirty_set = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            dirty_set[l] = up.up_wreq && up_cfg_is_writeable &&
                           (up.up_wbcast || wlane == l);
        end
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                word0[l]    <= '0;
                word1_hi[l] <= '0;
                word2[l]    <= '0;
                word3_lo[l] <= '0;
                fchk[l]     <= 8'(l);
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (dirty_set[l]) begin
                    case (up.up_waddr[1:0])
                        2'd0:    word0[l]    <= up.up_wdata;
                        2'd1:    word1_hi[l] <= up.up_wdata[31:W1_WR_LSB];
                        2'd2:    word2[l]    <= up.up_wdata;
                        default: word3_lo[l] <= up.up_wdata[W3_WR_MSB:0];
                    endcase
                end
            end
            if (state == ST_STORE) begin
                fchk[cur_lane] <= sum;
            end
        end
    end

    // Reads sample storage before this cycle's write lands.
    always_comb begin
        rd_word = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (rlane == l) begin
                rd_word = view[l][up.up_raddr[1:0]];
            end
        end
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            up.up_wack  <= 1'b0;
            up.up_rack  <= 1'b0;
            up.up_rdata <= '0;
        end else begin
            up.up_wack <= up.up_wreq;
            up.up_rack <= up.up_rreq;
            if (up.up_rreq) begin
                up.up_rdata <= rd_word;
            end
        end
    end

    always_comb begin
        core_beat = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int j = 0; j < WPB; j++) begin
                core_beat[l*BEAT_W + 32*j +: 32] =
                    view[l][2'(int'(core_ilas_config_addr) * WPB + j)];
            end
        end
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            core_ilas_config_data <= '0;
        end else if (core_ilas_config_rd) begin
            core_ilas_config_data <= core_beat;
        end
    end

    always_comb begin
        first_dirty = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (dirty[l]) begin
                first_dirty = LANE_W'(l);
            end
        end
    end

    assign start = (state == ST_IDLE) && (|dirty);

    // A write landing while its lane is being summed sets dirty again, and
    // set wins over clear, so a torn checksum is always followed by a rerun.
    always_comb begin
        dirty_clr = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            dirty_clr[l] = start && (first_dirty == LANE_W'(l));
        end
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            state    <= ST_IDLE;
            cur_lane <= '0;
            dirty    <= '0;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_lane <= first_dirty;
                        state    <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    if (done) begin
                        state <= ST_STORE;
                    end
                end
                ST_STORE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        octet = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (cur_lane == LANE_W'(l)) begin
                octet = view[l][octet_idx[3:2]][octet_idx[1:0]];
            end
        end
    end

    jesd204_up_ilas_fchk u_fchk (
        .clk       (up_clk),
        .rst       (up_reset),
        .start     (start),
        .octet     (octet),
        .octet_idx (octet_idx),
        .sum       (sum),
        .done      (done)
    );

    assign up_fchk_busy = (state != ST_IDLE) || (|dirty);

endmodule

// File: tb/tb_jesd204_up_ilas_cfg_bank.sv
// Randomized bench for the ILAS configuration bank with an abstract
// register/checksum model and directed literal scenarios.
module tb_jesd204_up_ilas_cfg_bank;
    import jesd204_up_pkg::*;

    localparam int NL  = 2;
    localparam int DPW = 8;
    localparam int AW  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_wr;
    logic               core_rd;
    logic [0:0]         core_addr;
    logic [NL*8*DPW-1:0] core_data;
    logic               busy;

    always #5 clk = ~clk;

    jesd204_up_ilas_cfg_bank_if #(.ADDR_W(AW)) bus ();

    jesd204_up_ilas_cfg_bank #(
        .NUM_LANES       (NL),
        .DATA_PATH_WIDTH (DPW)
    ) dut (
        .up_clk                (clk),
        .up_reset              (rst),
        .up                    (bus),
        .up_cfg_is_writeable   (cfg_wr),
        .core_ilas_config_rd   (core_rd),
        .core_ilas_config_addr (core_addr),
        .core_ilas_config_data (core_data),
        .up_fchk_busy          (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]  mw [NL][4];
    logic         pend_w = 1'b0;
    logic         pend_r = 1'b0;
    logic [31:0]  pend_rd = '0;
    logic [31:0]  pend_rmask = '1;
    logic [127:0] core_exp = '0;
    logic [127:0] core_mask = '1;
    logic         busy_n = 1'b0;
    int           mon_lane;
    int           mon_word;
    logic [31:0]  mon_tmp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int l = 0; l < NL; l++)
            for (int w = 0; w < 4; w++)
                mw[l][w] = '0;
    endfunction

    function automatic logic [7:0] calc_fchk(int l);
        logic [127:0] v;
        logic [7:0]   s;
        v = {mw[l][3], mw[l][2], mw[l][1] | 32'(l), mw[l][0]};
        s = '0;
        for (int n = 0; n <= 13; n++) s = s + v[8*n +: 8];
        return s;
    endfunction

    function automatic logic [31:0] exp_word(int l, int w);
        case (w)
            1:       return mw[l][1] | 32'(l);
            3:       return {calc_fchk(l), mw[l][3][23:0]};
            default: return mw[l][w];
        endcase
    endfunction

    // Expectations are formed at the sampling edge from the pre-write model.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            pend_w    = 1'b0;
            pend_r    = 1'b0;
            core_exp  = '0;
            core_mask = '1;
        end else begin
            pend_w = bus.up_wreq;
            pend_r = bus.up_rreq;
            if (bus.up_rreq) begin
                mon_lane   = int'(bus.up_raddr[2]);
                mon_word   = int'(bus.up_raddr[1:0]);
                pend_rd    = exp_word(mon_lane, mon_word);
                pend_rmask = (busy_n && mon_word == 3) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
            end
            if (core_rd) begin
                for (int l = 0; l < NL; l++) begin
                    for (int k = 0; k < DPW; k++) begin
                        mon_tmp = exp_word(l, (int'(core_addr) * DPW + k) / 4);
                        core_exp[l*64 + 8*k +: 8]  = mon_tmp[8*((int'(core_addr) * DPW + k) % 4) +: 8];
                        core_mask[l*64 + 8*k +: 8] =
                            (busy_n && (int'(core_addr) * DPW + k) == 15) ? 8'h00 : 8'hFF;
                    end
                end
            end
            if (bus.up_wreq && cfg_wr) begin
                for (int l = 0; l < NL; l++)
                    if (bus.up_wbcast || int'(bus.up_waddr[2]) == l)
                        mw[l][bus.up_waddr[1:0]] = bus.up_wdata & wr_mask(bus.up_waddr[1:0]);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("wack", 128'(bus.up_wack), 128'(pend_w));
            chk("rack", 128'(bus.up_rack), 128'(pend_r));
            if (pend_r) chk("rdata", 128'(bus.up_rdata & pend_rmask), 128'(pend_rd & pend_rmask));
            chk("core_data", core_data & core_mask, core_exp & core_mask);
        end
        busy_n = busy;
    end

    task automatic apply_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wack", 128'(bus.up_wack), 128'(0));
        chk("rst_rack", 128'(bus.up_rack), 128'(0));
        chk("rst_rdata", 128'(bus.up_rdata), 128'(0));
        chk("rst_core", core_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic do_write(input int lane, input int w, input logic [31:0] d, input logic bc);
        bus.up_wreq  = 1'b1;
        bus.up_waddr = 3'(lane * 4 + w);
        bus.up_wdata = d;
        bus.up_wbcast = bc;
        @(posedge clk);
        #1;
        bus.up_wreq  = 1'b0;
        bus.up_wbcast = 1'b0;
    endtask

    task automatic do_read(input int lane, input int w);
        bus.up_rreq  = 1'b1;
        bus.up_raddr = 3'(lane * 4 + w);
        @(posedge clk);
        #1;
        bus.up_rreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_lit(input int lane, input int w, input logic [31:0] lit, input string name);
        do_read(lane, w);
        chk(name, 128'(bus.up_rdata), 128'(lit));
    endtask

    task automatic wait_idle(input string name);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, 128'(cnt < 200), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        bus.up_wreq = 1'b0; bus.up_waddr = '0; bus.up_wdata = '0; bus.up_wbcast = 1'b0;
        bus.up_rreq = 1'b0; bus.up_raddr = '0;
        cfg_wr = 1'b1; core_rd = 1'b0; core_addr = '0;

        apply_reset();
        read_lit(1, 1, 32'h0000_0001, "reset_lane1_word1");
        read_lit(1, 3, 32'h0100_0000, "reset_lane1_word3");
        chk("reset_busy_low", 128'(busy), 128'(0));

        do_write(0, 2, 32'h0000_0010, 1'b1);
        wait_idle("bcast_idle");
        read_lit(0, 2, 32'h0000_0010, "bcast_lane0_word2");
        read_lit(1, 2, 32'h0000_0010, "bcast_lane1_word2");
        read_lit(0, 3, 32'h1000_0000, "bcast_lane0_fchk");
        read_lit(1, 3, 32'h1100_0000, "bcast_lane1_fchk");

        apply_reset();
        do_write(0, 0, 32'h0403_0201, 1'b0);
        wait_idle("w0_idle");
        read_lit(0, 3, 32'h0A00_0000, "lane0_fchk_0a");
        do_write(0, 1, 32'hFFFF_FFFF, 1'b0);
        wait_idle("w1_idle");
        read_lit(0, 1, 32'hFFFF_FFE0, "lane0_word1_mask");
        read_lit(0, 3, 32'hE700_0000, "lane0_fchk_e7");

        core_rd = 1'b1; core_addr = 1'b1;
        @(posedge clk);
        #1 core_rd = 1'b0;
        @(negedge clk);
        chk("core_beat1_lane0_hi", 128'(core_data[63:32]), 128'(32'hE700_0000));
        chk("core_beat1_lane0_lo", 128'(core_data[31:0]), 128'(0));

        cfg_wr = 1'b0;
        do_write(1, 0, 32'hFFFF_FFFF, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("readonly_busy_low", 128'(busy), 128'(0));
        end
        read_lit(1, 0, 32'h0000_0000, "readonly_unchanged");
        cfg_wr = 1'b1;

        do_write(0, 0, 32'h0000_0005, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        do_write(0, 0, 32'h0000_0007, 1'b0);
        cnt = 0;
        while (busy && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_sum_two_passes", 128'(cnt > 20 && cnt < 300), 128'(1));
        @(posedge clk);
        #1;
        read_lit(0, 0, 32'h0000_0007, "mid_sum_word0");
        read_lit(0, 3, 32'hE400_0000, "mid_sum_fchk");

        repeat (400) begin
            bus.up_wreq   = ($urandom_range(0, 3) == 0);
            bus.up_waddr  = 3'($urandom_range(0, 7));
            bus.up_wdata  = $urandom;
            bus.up_wbcast = ($urandom_range(0, 4) == 0);
            cfg_wr        = ($urandom_range(0, 7) != 0);
            bus.up_rreq   = 1'($urandom_range(0, 1));
            bus.up_raddr  = 3'($urandom_range(0, 7));
            core_rd       = 1'($urandom_range(0, 1));
            core_addr     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.up_wreq = 1'b0; bus.up_rreq = 1'b0; bus.up_wbcast = 1'b0;
        core_rd = 1'b0; cfg_wr = 1'b1;
        wait_idle("random_idle");
        for (int l = 0; l < NL; l++)
            for (int w = 0; w < 4; w++)
                do_read(l, w);
        for (int a = 0; a < 2; a++) begin
            core_rd = 1'b1; core_addr = 1'(a);
            @(posedge clk);
            #1;
        end
        core_rd = 1'b0;
        @(negedge clk);

        do_write(1, 2, 32'h0000_00A5, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_busy_mid_sum", 128'(busy), 128'(1));
        apply_reset();
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        chk("abort_no_residual_busy", 128'(cnt), 128'(0));
        @(posedge clk);
        #1;
        read_lit(1, 2, 32'h0000_0000, "abort_lane1_word2");
        read_lit(1, 3, 32'h0100_0000, "abort_lane1_fchk");
        read_lit(0, 3, 32'h0000_0000, "abort_lane0_fchk");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
